// File: rtl/count_display_driver.sv
// count_display_driver
//   Converts a 7-bit binary count into two BCD digits and drives a
//   two-digit multiplexed 7-segment display.
//
//   The conversion is an iterative subtract-by-10 FSM. Both digits and the
//   error flag are loaded into the display registers on a single edge, so a
//   half-updated pair of digits is never shown. Values above 99 show "--".
//
//   State table
//     IDLE | waiting for a new Value (or the post-reset dirty flag)
//     CONV | subtracting 10 from the remainder, one step per cycle
//     DONE | loading tens/ones/err into the display registers together
//
// Ports
//   Clk     in   system clock
//   reset   in   synchronous, active-high reset
//   Value   in   [6:0] binary count (0..99 valid, 100..127 shown as "--")
//   enable  in   1 = display on, 0 = all anodes inactive and segments off
//   seg     out  [6:0] segments {g,f,e,d,c,b,a}, registered, pin polarity
//   dp      out  decimal point, held inactive
//   an      out  [1:0] an[0] = ones digit, an[1] = tens digit, registered
//   busy    out  conversion in progress
module count_display_driver #(
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [6:0] Value,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  // XOR masks turn the internal active-high form into pin polarity.
  localparam logic [6:0]  LP_SEG_XOR    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]  LP_AN_XOR     = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [23:0] LP_REFRESH_TC = 24'(REFRESH_DIV - 1);

  state_t      r_state, w_state_nx;
  logic        r_busy, w_busy_nx;
  logic [6:0]  r_cap, w_cap_nx;
  logic [6:0]  r_rem, w_rem_nx;
  logic [3:0]  r_tens_acc, w_tens_acc_nx;
  logic [3:0]  r_ones_acc, w_ones_acc_nx;
  logic        r_err_acc, w_err_acc_nx;
  logic        r_dirty, w_dirty_nx;
  logic [6:0]  r_shadow, w_shadow_nx;
  logic        w_load;

  logic [3:0]  r_tens, r_ones;
  logic        r_err;

  logic [23:0] r_refresh_cnt;
  logic        r_digit_sel;

  logic [6:0]  w_seg_hi;
  logic [1:0]  w_an_hi;
  logic [6:0]  r_seg;
  logic [1:0]  r_an;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_cap      <= 7'd0;
      r_rem      <= 7'd0;
      r_tens_acc <= 4'd0;
      r_ones_acc <= 4'd0;
      r_err_acc  <= 1'b0;
      r_dirty    <= 1'b1;
      r_shadow   <= 7'd0;
    end else begin
      r_state    <= w_state_nx;
      r_busy     <= w_busy_nx;
      r_cap      <= w_cap_nx;
      r_rem      <= w_rem_nx;
      r_tens_acc <= w_tens_acc_nx;
      r_ones_acc <= w_ones_acc_nx;
      r_err_acc  <= w_err_acc_nx;
      r_dirty    <= w_dirty_nx;
      r_shadow   <= w_shadow_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_busy_nx     = r_busy;
    w_cap_nx      = r_cap;
    w_rem_nx      = r_rem;
    w_tens_acc_nx = r_tens_acc;
    w_ones_acc_nx = r_ones_acc;
    w_err_acc_nx  = r_err_acc;
    w_dirty_nx    = r_dirty;
    w_shadow_nx   = r_shadow;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Value is only sampled here, so changes during a conversion are
        // picked up by the compare against shadow once DONE returns.
        if (r_dirty || (Value != r_shadow)) begin
          w_cap_nx      = Value;
          w_rem_nx      = Value;
          w_tens_acc_nx = 4'd0;
          w_dirty_nx    = 1'b0;
          w_busy_nx     = 1'b1;
          if (Value <= 7'd99) begin
            w_state_nx = S_CONV;
          end else begin
            w_err_acc_nx = 1'b1;
            w_state_nx   = S_DONE;
          end
        end
      end
      S_CONV: begin
        if (r_rem >= 7'd10) begin
          w_rem_nx      = r_rem - 7'd10;
          w_tens_acc_nx = r_tens_acc + 4'd1;
        end else begin
          w_ones_acc_nx = r_rem[3:0];
          w_err_acc_nx  = 1'b0;
          w_state_nx    = S_DONE;
        end
      end
      S_DONE: begin
        w_load      = 1'b1;
        w_shadow_nx = r_cap;
        w_busy_nx   = 1'b0;
        w_state_nx  = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
      r_err  <= 1'b0;
    end else if (w_load) begin
      r_tens <= r_tens_acc;
      r_ones <= r_ones_acc;
      r_err  <= r_err_acc;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_refresh_cnt <= 24'd0;
      r_digit_sel   <= 1'b0;
    end else if (r_refresh_cnt == LP_REFRESH_TC) begin
      r_refresh_cnt <= 24'd0;
      r_digit_sel   <= ~r_digit_sel;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 24'd1;
    end
  end

  always_comb begin
    w_seg_hi = 7'h00;
    w_an_hi  = 2'b00;
    if (enable) begin
      if (!r_digit_sel) begin
        w_an_hi  = 2'b01;
        w_seg_hi = r_err ? 7'h40 : f_decode(r_ones);
      end else if (r_err) begin
        w_an_hi  = 2'b10;
        w_seg_hi = 7'h40;
      end else if (!((BLANK_LZ != 0) && (r_tens == 4'd0))) begin
        w_an_hi  = 2'b10;
        w_seg_hi = f_decode(r_tens);
      end
    end
  end

  // seg and an share one register stage so an anode never meets stale segments.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_seg <= LP_SEG_XOR;
      r_an  <= LP_AN_XOR;
    end else begin
      r_seg <= w_seg_hi ^ LP_SEG_XOR;
      r_an  <= w_an_hi ^ LP_AN_XOR;
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign dp   = LP_SEG_XOR[0];
  assign busy = r_busy;

endmodule
